// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Qualifies the clock wizard's asynchronous lock status. It then releases the
//   system reset and, after a fixed delay, the DDR3/memory-controller reset.
//   It also drives a per-state blink pattern on the core-board status LED.
//   Everything runs on the 100 MHz wizard output clock.
//
// Ports
//   i_clk           100 MHz clock from the clock wizard
//   i_rst_n         asynchronous active-low reset
//   i_locked        wizard lock, asynchronous to i_clk
//   o_sys_rst_n     system-logic reset, active-low
//   o_mem_rst_n     memory-controller reset, active-low
//   o_ready         high once fully out of reset (RUN)
//   o_core_led      status LED, active-low (0 = lit)
//   o_lock_loss_cnt saturating count of lock losses since i_rst_n
module clk_rst_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MEM_DELAY_CYCLES   = 20000,
    parameter int LED_FAST_CYCLES    = 5_000_000,
    parameter int LED_SLOW_CYCLES    = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_locked,
    output logic       o_sys_rst_n,
    output logic       o_mem_rst_n,
    output logic       o_ready,
    output logic       o_core_led,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int SEQ_MAX = (LOCK_STABLE_CYCLES > MEM_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : MEM_DELAY_CYCLES;
    localparam int CW      = ($clog2(SEQ_MAX) < 1) ? 1 : $clog2(SEQ_MAX);
    localparam int LED_MAX = (LED_FAST_CYCLES > LED_SLOW_CYCLES) ? LED_FAST_CYCLES : LED_SLOW_CYCLES;
    localparam int LW      = ($clog2(LED_MAX) < 1) ? 1 : $clog2(LED_MAX);

    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LAST    = CW'(MEM_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [LW-1:0] FAST_LAST   = LW'(LED_FAST_CYCLES - 1);
    localparam logic [LW-1:0] SLOW_LAST   = LW'(LED_SLOW_CYCLES - 1);
    localparam logic [LW-1:0] LED_ONE     = LW'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        SYS_UP    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            lock_s1, locked_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   led_cnt_q, led_cnt_d;
    logic            sys_d, mem_d, rdy_d, led_d;
    logic [7:0]      loss_d;
    logic            fast_wrap, slow_wrap;

    assign fast_wrap = (led_cnt_q == FAST_LAST);
    assign slow_wrap = (led_cnt_q == SLOW_LAST);

    // 2-flop synchronizer for the asynchronous lock input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_s1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            lock_s1  <= i_locked;
            locked_s <= lock_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= WAIT_LOCK;
            cnt_q           <= '0;
            led_cnt_q       <= '0;
            o_sys_rst_n     <= 1'b0;
            o_mem_rst_n     <= 1'b0;
            o_ready         <= 1'b0;
            o_core_led      <= 1'b1;
            o_lock_loss_cnt <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            led_cnt_q       <= led_cnt_d;
            o_sys_rst_n     <= sys_d;
            o_mem_rst_n     <= mem_d;
            o_ready         <= rdy_d;
            o_core_led      <= led_d;
            o_lock_loss_cnt <= loss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        led_cnt_d = led_cnt_q;
        sys_d     = o_sys_rst_n;
        mem_d     = o_mem_rst_n;
        rdy_d     = o_ready;
        led_d     = o_core_led;
        loss_d    = o_lock_loss_cnt;

        if (state_q == WAIT_LOCK) begin
            sys_d     = 1'b0;
            mem_d     = 1'b0;
            rdy_d     = 1'b0;
            led_d     = 1'b1;
            led_cnt_d = '0;
            if (locked_s) begin
                state_d = STABLE;
                cnt_d   = '0;
                led_d   = 1'b0;
            end
        end else if (!locked_s) begin
            // Lock loss wins over any terminal count on this edge
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            sys_d     = 1'b0;
            mem_d     = 1'b0;
            rdy_d     = 1'b0;
            led_d     = 1'b1;
            led_cnt_d = '0;
            if (o_lock_loss_cnt != 8'hFF)
                loss_d = o_lock_loss_cnt + 8'd1;
        end else begin
            // Blink: fast through STABLE/SYS_UP (no restart between them), slow in RUN
            if ((state_q == RUN) ? slow_wrap : fast_wrap) begin
                led_d     = ~o_core_led;
                led_cnt_d = '0;
            end else begin
                led_cnt_d = led_cnt_q + LED_ONE;
            end

            case (state_q)
                STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = SYS_UP;
                        sys_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                SYS_UP: begin
                    if (cnt_q == MEM_LAST) begin
                        state_d   = RUN;
                        mem_d     = 1'b1;
                        rdy_d     = 1'b1;
                        led_d     = 1'b0;   // RUN entry restarts the blink lit
                        led_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: ;                  // RUN holds
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;
    localparam int L = 16;
    localparam int M = 32;
    localparam int F = 4;
    localparam int S = 10;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_locked = 1'b0;
    logic       o_sys_rst_n, o_mem_rst_n, o_ready, o_core_led;
    logic [7:0] o_lock_loss_cnt;

    clk_rst_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .MEM_DELAY_CYCLES  (M),
        .LED_FAST_CYCLES   (F),
        .LED_SLOW_CYCLES   (S)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_locked       (i_locked),
        .o_sys_rst_n    (o_sys_rst_n),
        .o_mem_rst_n    (o_mem_rst_n),
        .o_ready        (o_ready),
        .o_core_led     (o_core_led),
        .o_lock_loss_cnt(o_lock_loss_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: k = number of consecutive edges at which the
    // (two-edge delayed) lock has been seen high. Every output follows from k.
    int k      = 0;
    int loss_m = 0;
    bit d1 = 1'b0, d2 = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k      <= 0;
            loss_m <= 0;
            d1     <= 1'b0;
            d2     <= 1'b0;
        end else begin
            k      <= d2 ? k + 1 : 0;
            loss_m <= (!d2 && k > 0 && loss_m < 255) ? loss_m + 1 : loss_m;
            d2     <= d1;
            d1     <= i_locked;
        end
    end

    function automatic logic exp_led(input int kk);
        if (kk == 0)         return 1'b1;
        if (kk <= L + M)     return logic'(((kk - 1) / F) % 2);
        return logic'(((kk - L - M - 1) / S) % 2);
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("sys",  32'(o_sys_rst_n),     32'(k >= L + 1));
            chk("mem",  32'(o_mem_rst_n),     32'(k >= L + M + 1));
            chk("rdy",  32'(o_ready),         32'(k >= L + M + 1));
            chk("led",  32'(o_core_led),      32'(exp_led(k)));
            chk("loss", 32'(o_lock_loss_cnt), 32'(loss_m));
        end
    end

    // Raise lock and measure edges (edge 0 = first sampling edge) to release
    task automatic bringup(input string tag);
        int t_sys, t_rdy;
        t_sys = -1;
        t_rdy = -1;
        @(negedge i_clk);
        i_locked = 1'b1;
        for (int e = 0; e < 200 && t_rdy < 0; e++) begin
            @(posedge i_clk);
            #1;
            if (o_sys_rst_n && t_sys < 0) t_sys = e;
            if (o_ready) begin
                t_rdy = e;
                chk({tag, "_mem_at_rdy"}, 32'(o_mem_rst_n), 32'd1);
                chk({tag, "_led_run_entry"}, 32'(o_core_led), 32'd0);
            end
        end
        chk({tag, "_sys_lat"}, t_sys, L + 2);
        chk({tag, "_rdy_lat"}, t_rdy, L + M + 2);
    endtask

    task automatic reset_pulse();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #2;
        chk("rst_loss", 32'(o_lock_loss_cnt), 32'd0);
        chk("rst_sys",  32'(o_sys_rst_n),     32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rv_sys",  32'(o_sys_rst_n),     32'd0);
        chk("rv_mem",  32'(o_mem_rst_n),     32'd0);
        chk("rv_rdy",  32'(o_ready),         32'd0);
        chk("rv_led",  32'(o_core_led),      32'd1);
        chk("rv_loss", 32'(o_lock_loss_cnt), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Clean bring-up
        bringup("up1");
        chk("up1_loss", 32'(o_lock_loss_cnt), 32'd0);

        // Lock loss in RUN: outputs drop two edges after sampling
        @(negedge i_clk);
        i_locked = 1'b0;
        @(posedge i_clk); #1 chk("ll_j",  32'(o_ready), 32'd1);
        @(posedge i_clk); #1 chk("ll_j1", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        chk("ll_j2_rdy", 32'(o_ready),     32'd0);
        chk("ll_j2_sys", 32'(o_sys_rst_n), 32'd0);
        chk("ll_j2_mem", 32'(o_mem_rst_n), 32'd0);
        chk("ll_cnt",    32'(o_lock_loss_cnt), 32'd1);
        repeat (4) @(negedge i_clk);
        bringup("up2");

        // Glitch during STABLE restarts qualification
        reset_pulse();
        @(negedge i_clk);
        i_locked = 1'b1;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        i_locked = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("gl_sys", 32'(o_sys_rst_n), 32'd0);
        bringup("gl");
        chk("gl_loss", 32'(o_lock_loss_cnt), 32'd1);

        // Random lock activity against the model
        for (int s = 0; s < 40; s++) begin
            @(negedge i_clk);
            i_locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 70)) @(negedge i_clk);
        end

        // Saturation of the loss counter
        for (int t = 0; t < 300; t++) begin
            @(negedge i_clk); i_locked = 1'b1;
            repeat (3) @(negedge i_clk);
            i_locked = 1'b0;
            repeat (2) @(negedge i_clk);
        end
        repeat (4) @(negedge i_clk);
        chk("sat", 32'(o_lock_loss_cnt), 32'd255);
        reset_pulse();

        // Asynchronous reset in the middle of SYS_UP
        @(negedge i_clk);
        i_locked = 1'b1;
        repeat (25) @(posedge i_clk);
        #1 chk("su_sys", 32'(o_sys_rst_n), 32'd1);
        chk("su_rdy", 32'(o_ready), 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("ar_sys",  32'(o_sys_rst_n),     32'd0);
        chk("ar_mem",  32'(o_mem_rst_n),     32'd0);
        chk("ar_rdy",  32'(o_ready),         32'd0);
        chk("ar_led",  32'(o_core_led),      32'd1);
        chk("ar_loss", 32'(o_lock_loss_cnt), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
